ifu_prefetch: RTL

- Next-generation instruction fetch unit for the RISC-V CPU. It replaces the combinational, zero-latency instruction read with a bus-based fetch that tolerates variable memory latency.
- Issues one instruction read at a time to instruction memory and buffers responses in a parametrised FIFO of {pc, instr, fault}.
- Presents buffered instructions to decode over a valid/ready handshake.
- Supports pipeline redirect (branch/jump), flushing the FIFO and discarding the stale in-flight response.

---
 rtl/ifu_prefetch_if.sv | 38 +++
 rtl/ifu_prefetch.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/ifu_prefetch_if.sv
// Fetch-unit bus bundle: memory request/response, redirect and decode handshake.
// The fetch unit uses the master view; memory and decode sit on the slave view.
interface ifu_prefetch_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_err;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_pc;
  logic [XLEN-1:0] inst;
  logic            inst_fault;
  logic            inst_ebreak;

  modport master (
    output req_valid, req_addr,
    input  req_ready,
    input  rsp_valid, rsp_data, rsp_err,
    input  redirect_valid, redirect_pc,
    output inst_valid, inst_pc, inst, inst_fault, inst_ebreak,
    input  inst_ready
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready,
    output rsp_valid, rsp_data, rsp_err,
    output redirect_valid, redirect_pc,
    input  inst_valid, inst_pc, inst, inst_fault, inst_ebreak,
    output inst_ready
  );
endinterface

// File: rtl/ifu_prefetch.sv
// Instruction prefetcher: one outstanding memory read at a time, responses
// buffered in a small FIFO of {pc, instr, fault} and handed to decode.
module ifu_prefetch #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic          clk,
  input  logic          rst,
  ifu_prefetch_if.master bus
);
  localparam int              PW           = $clog2(DEPTH);
  localparam logic [PW+1:0]   DEPTH_W      = (PW+2)'(DEPTH);
  localparam logic [XLEN-1:0] EBREAK_INSTR = XLEN'(32'h0010_0073);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] issue_pc_q, issue_pc_d;
  logic            busy_q, busy_d;
  logic            drop_q, drop_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     count_q, count_d;

  logic [XLEN-1:0] buf_pc_q    [DEPTH];
  logic [XLEN-1:0] buf_instr_q [DEPTH];
  logic            buf_fault_q [DEPTH];

  logic            arriving_s;
  logic [PW+1:0]   occupancy_s;
  logic            can_issue_s;
  logic            fire_s;
  logic            rsp_take_s;
  logic            push_s;
  logic            pop_s;
  logic            head_valid_s;
  logic            unused_redirect_lsb_s;

  assign unused_redirect_lsb_s = ^bus.redirect_pc[1:0];

  // Issue only when the response is certain to find a free slot; a same-cycle pop is not credited.
  always_comb begin
    arriving_s   = busy_q & bus.rsp_valid & ~drop_q;
    occupancy_s  = {1'b0, count_q} + {{(PW+1){1'b0}}, arriving_s};
    can_issue_s  = ~rst & ~bus.redirect_valid & (~busy_q | bus.rsp_valid) & (occupancy_s < DEPTH_W);
    fire_s       = can_issue_s & bus.req_ready;
    rsp_take_s   = busy_q & bus.rsp_valid;
    push_s       = rsp_take_s & ~drop_q & ~bus.redirect_valid;
    head_valid_s = (count_q != {(PW+1){1'b0}});
    pop_s        = head_valid_s & bus.inst_ready & ~bus.redirect_valid;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    issue_pc_d = issue_pc_q;
    busy_d     = busy_q;
    drop_d     = drop_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (bus.redirect_valid) begin
      // A response still outstanding belongs to the old stream and must be swallowed.
      fetch_pc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
      busy_d     = busy_q & ~bus.rsp_valid;
      drop_d     = busy_q & ~bus.rsp_valid;
      wr_ptr_d   = {PW{1'b0}};
      rd_ptr_d   = {PW{1'b0}};
      count_d    = {(PW+1){1'b0}};
    end else begin
      if (fire_s) begin
        busy_d     = 1'b1;
        fetch_pc_d = fetch_pc_q + XLEN'(4);
        issue_pc_d = fetch_pc_q;
      end else if (rsp_take_s) begin
        busy_d = 1'b0;
      end else begin
        busy_d = busy_q;
      end
      if (rsp_take_s & drop_q) begin
        drop_d = 1'b0;
      end else begin
        drop_d = drop_q;
      end
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      issue_pc_q <= RESET_PC;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      count_q    <= {(PW+1){1'b0}};
    end else begin
      fetch_pc_q <= fetch_pc_d;
      issue_pc_q <= issue_pc_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_s & ~rst) begin
      buf_pc_q[wr_ptr_q]    <= issue_pc_q;
      buf_instr_q[wr_ptr_q] <= bus.rsp_data;
      buf_fault_q[wr_ptr_q] <= bus.rsp_err;
    end
  end

  always_comb begin
    if (rst) begin
      bus.req_valid   = 1'b0;
      bus.req_addr    = {XLEN{1'b0}};
      bus.inst_valid  = 1'b0;
      bus.inst_pc     = {XLEN{1'b0}};
      bus.inst        = {XLEN{1'b0}};
      bus.inst_fault  = 1'b0;
      bus.inst_ebreak = 1'b0;
    end else begin
      bus.req_valid   = can_issue_s;
      bus.req_addr    = fetch_pc_q;
      bus.inst_valid  = head_valid_s;
      bus.inst_pc     = buf_pc_q[rd_ptr_q];
      bus.inst        = buf_fault_q[rd_ptr_q] ? {XLEN{1'b0}} : buf_instr_q[rd_ptr_q];
      bus.inst_fault  = buf_fault_q[rd_ptr_q];
      bus.inst_ebreak = ~buf_fault_q[rd_ptr_q] & (buf_instr_q[rd_ptr_q] == EBREAK_INSTR);
    end
  end
endmodule
